// File: rtl/sysarray_param_if.sv
// Handshake and data bundle for the parameterised systolic matrix multiplier.
// The master side issues jobs and operands; the slave side is the array.
interface sysarray_param_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 64,
  parameter int KW = 8
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] inp_west;
  logic [N*DW-1:0] inp_north;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_row;
  logic [N*AW-1:0] out_data;
  logic            done;

  modport master (
    output start, k_len, in_valid, inp_west, inp_north, out_ready,
    input  in_ready, busy, out_valid, out_row, out_data, done
  );

  modport slave (
    input  start, k_len, in_valid, inp_west, inp_north, out_ready,
    output in_ready, busy, out_valid, out_row, out_data, done
  );
endinterface

// File: rtl/sysarray_param.sv
// N x N output-stationary systolic array computing C = A * B over K beats,
// with internal input skewing, drain phase and row-by-row result readout.
module sysarray_param #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 64,
  parameter int KW = 8
) (
  input logic             clk,
  input logic             rst,
  sysarray_param_if.slave sa
);
  localparam int RW  = (N > 1) ? $clog2(N) : 1;
  localparam int DCW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, READ} state_t;

  state_t         state;
  logic [KW-1:0]  k_lat;
  logic [KW-1:0]  beat_cnt;
  logic [DCW-1:0] drain_cnt;
  logic [RW-1:0]  row;
  logic           done_q;

  logic beat, step, clear;

  logic [DW-1:0] inj_w [N];
  logic [DW-1:0] inj_n [N];
  logic [DW-1:0] wbus  [N][N];
  logic [DW-1:0] nbus  [N][N];
  logic [AW-1:0] acc   [N][N];

  assign beat  = sa.in_valid && (state == LOAD);
  assign step  = beat || (state == DRAIN);
  assign clear = (state == IDLE) && sa.start;

  assign sa.in_ready  = (state == LOAD);
  assign sa.busy      = (state != IDLE);
  assign sa.out_valid = (state == READ);
  assign sa.out_row   = row;
  assign sa.done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_lat     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      row       <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sa.start) begin
            k_lat     <= sa.k_len;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            row       <= '0;
            state     <= (sa.k_len == '0) ? READ : LOAD;
          end
        end
        LOAD: begin
          if (beat) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt == k_lat - KW'(1))
              state <= (N == 1) ? READ : DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DCW'(1);
          if (drain_cnt == DCW'(2 * N - 3))
            state <= READ;
        end
        READ: begin
          if (sa.out_ready) begin
            if (row == RW'(N - 1)) begin
              row    <= '0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              row <= row + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Drain steps push zeros so trailing wavefronts finish without new products.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      inj_w[i] = (state == LOAD) ? sa.inp_west[i*DW +: DW]  : '0;
      inj_n[i] = (state == LOAD) ? sa.inp_north[i*DW +: DW] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign wbus[0][0] = inj_w[0];
      assign nbus[0][0] = inj_n[0];
    end else begin : g_delay
      logic [DW-1:0] sw [i];
      logic [DW-1:0] sn [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
          for (int s = 0; s < i; s++) begin
            sw[s] <= '0;
            sn[s] <= '0;
          end
        end else if (step) begin
          sw[0] <= inj_w[i];
          sn[0] <= inj_n[i];
          for (int s = 1; s < i; s++) begin
            sw[s] <= sw[s-1];
            sn[s] <= sn[s-1];
          end
        end
      end
      assign wbus[i][0] = sw[i-1];
      assign nbus[0][i] = sn[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic [AW-1:0]          acc_q;
      logic signed [2*DW-1:0] prod;

      assign prod      = $signed(wbus[i][j]) * $signed(nbus[i][j]);
      assign acc[i][j] = acc_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst || clear)
          acc_q <= '0;
        else if (step)
          acc_q <= acc_q + AW'(prod);
      end

      if (j < N - 1) begin : g_east
        logic [DW-1:0] a_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst || clear)
            a_q <= '0;
          else if (step)
            a_q <= wbus[i][j];
        end
        assign wbus[i][j+1] = a_q;
      end

      if (i < N - 1) begin : g_south
        logic [DW-1:0] b_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst || clear)
            b_q <= '0;
          else if (step)
            b_q <= nbus[i][j];
        end
        assign nbus[i+1][j] = b_q;
      end
    end
  end

  always_comb begin
    sa.out_data = '0;
    for (int r = 0; r < N; r++) begin
      if (row == RW'(r)) begin
        for (int j = 0; j < N; j++)
          sa.out_data[j*AW +: AW] = acc[r][j];
      end
    end
  end
endmodule

// File: tb/tb_sysarray_param.sv
// Directed bench for sysarray_param: a 2x2 8-bit instance and a 4x4 32-bit
// instance, each exercised with hand-computed matrix products.
module tb_sysarray_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  sysarray_param_if #(.N(2), .DW(8),  .AW(16), .KW(8)) s2 ();
  sysarray_param_if #(.N(4), .DW(32), .AW(64), .KW(8)) s4 ();

  sysarray_param #(.N(2), .DW(8),  .AW(16), .KW(8)) dut2 (.clk(clk), .rst(rst), .sa(s2.slave));
  sysarray_param #(.N(4), .DW(32), .AW(64), .KW(8)) dut4 (.clk(clk), .rst(rst), .sa(s4.slave));

  logic [15:0]  w2 [8];
  logic [15:0]  n2 [8];
  logic [127:0] w4 [8];
  logic [127:0] n4 [8];

  logic [31:0]  got2  [2];
  logic [0:0]   grow2 [2];
  logic [255:0] got4  [4];
  logic [1:0]   grow4 [4];
  logic         done_a, done_b, busy_a;
  bit           tmo;

  task automatic feed2(input int k, input bit stall, output int cyc);
    s2.start = 1'b1;
    s2.k_len = 8'(k);
    @(negedge clk);
    cyc = 1;
    s2.start = 1'b0;
    for (int b = 0; b < k; b++) begin
      s2.in_valid = 1'b1;
      s2.inp_west = w2[b];
      s2.inp_north = n2[b];
      @(negedge clk);
      cyc++;
      if (stall) begin
        s2.in_valid = 1'b0;
        s2.inp_west = 16'($urandom);
        s2.inp_north = 16'($urandom);
        @(negedge clk);
        cyc++;
      end
    end
    s2.in_valid = 1'b0;
  endtask

  task automatic feed4(input int k, input bit stall, output int cyc);
    s4.start = 1'b1;
    s4.k_len = 8'(k);
    @(negedge clk);
    cyc = 1;
    s4.start = 1'b0;
    for (int b = 0; b < k; b++) begin
      s4.in_valid = 1'b1;
      s4.inp_west = w4[b];
      s4.inp_north = n4[b];
      @(negedge clk);
      cyc++;
      if (stall) begin
        s4.in_valid = 1'b0;
        s4.inp_west = {4{$urandom}};
        s4.inp_north = {4{$urandom}};
        @(negedge clk);
        cyc++;
      end
    end
    s4.in_valid = 1'b0;
  endtask

  // Accepts rows one at a time and records what each presented row held.
  task automatic collect2();
    int w;
    tmo = 1'b0;
    for (int r = 0; r < 2; r++) begin
      w = 0;
      while (!s2.out_valid && w < 60) begin @(negedge clk); w++; end
      if (!s2.out_valid) tmo = 1'b1;
      grow2[r] = s2.out_row;
      got2[r] = s2.out_data;
      s2.out_ready = 1'b1;
      @(negedge clk);
      s2.out_ready = 1'b0;
    end
    done_a = s2.done;
    busy_a = s2.busy;
    @(negedge clk);
    done_b = s2.done;
  endtask

  task automatic collect4(input int nrows);
    int w;
    tmo = 1'b0;
    for (int r = 0; r < nrows; r++) begin
      w = 0;
      while (!s4.out_valid && w < 60) begin @(negedge clk); w++; end
      if (!s4.out_valid) tmo = 1'b1;
      grow4[r] = s4.out_row;
      got4[r] = s4.out_data;
      s4.out_ready = 1'b1;
      @(negedge clk);
      s4.out_ready = 1'b0;
    end
    done_a = s4.done;
    busy_a = s4.busy;
    @(negedge clk);
    done_b = s4.done;
  endtask

  task automatic wait_valid4(inout int cyc);
    while (!s4.out_valid && cyc < 60) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s2.start = 1'b1; s4.start = 1'b1;
    s2.in_valid = 1'b1; s4.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (s2.in_ready !== 1'b0)  $display("FAIL reset_in_ready2: got %b want 0", s2.in_ready); else passed++;
    total++; if (s2.busy !== 1'b0)      $display("FAIL reset_busy2: got %b want 0", s2.busy); else passed++;
    total++; if (s2.out_valid !== 1'b0) $display("FAIL reset_out_valid2: got %b want 0", s2.out_valid); else passed++;
    total++; if (s2.out_data !== 32'h0) $display("FAIL reset_out_data2: got %h want 0", s2.out_data); else passed++;
    total++; if (s4.out_row !== 2'd0)   $display("FAIL reset_out_row4: got %0d want 0", s4.out_row); else passed++;
    total++; if (s4.done !== 1'b0)      $display("FAIL reset_done4: got %b want 0", s4.done); else passed++;
    total++; if (s4.out_data !== 256'h0) $display("FAIL reset_out_data4: got %h want 0", s4.out_data); else passed++;
    s2.start = 1'b0; s4.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++; if (s4.busy !== 1'b0)     $display("FAIL post_reset_busy4: got %b want 0", s4.busy); else passed++;
    total++; if (s4.in_ready !== 1'b0) $display("FAIL post_reset_in_ready4: got %b want 0", s4.in_ready); else passed++;
    s2.in_valid = 1'b0; s4.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int cyc;
    w2[0] = {8'd3, 8'd1}; n2[0] = {8'd0, 8'd1};
    w2[1] = {8'd4, 8'd2}; n2[1] = {8'd1, 8'd0};
    feed2(2, 1'b0, cyc);
    while (!s2.out_valid && cyc < 60) begin @(negedge clk); cyc++; end
    total++; if (cyc != 5) $display("FAIL identity_latency: got %0d want 5", cyc); else passed++;
    collect2();
    total++; if (tmo !== 1'b0) $display("FAIL identity_timeout: got %b want 0", tmo); else passed++;
    total++; if (got2[0] !== {16'd2, 16'd1}) $display("FAIL identity_row0: got %h want 00020001", got2[0]); else passed++;
    total++; if (got2[1] !== {16'd4, 16'd3}) $display("FAIL identity_row1: got %h want 00040003", got2[1]); else passed++;
    total++; if (grow2[1] !== 1'b1) $display("FAIL identity_rowidx1: got %0d want 1", grow2[1]); else passed++;
    total++; if (done_a !== 1'b1) $display("FAIL identity_done_pulse: got %b want 1", done_a); else passed++;
    total++; if (done_b !== 1'b0) $display("FAIL identity_done_single: got %b want 0", done_b); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL identity_busy_after: got %b want 0", busy_a); else passed++;
  endtask

  task automatic test_signed_dw8();
    int cyc;
    w2[0] = {8'd0, 8'h80}; n2[0] = {8'd0, 8'h80};
    feed2(1, 1'b0, cyc);
    collect2();
    total++; if (got2[0] !== {16'h0000, 16'h4000}) $display("FAIL signed_min_row0: got %h want 00004000", got2[0]); else passed++;
    total++; if (got2[1] !== 32'h0) $display("FAIL signed_min_row1: got %h want 0", got2[1]); else passed++;
    for (int b = 0; b < 3; b++) begin
      w2[b] = {8'd0, 8'hFF};
      n2[b] = {8'd0, 8'd5};
    end
    feed2(3, 1'b0, cyc);
    collect2();
    total++; if (got2[0] !== {16'h0000, 16'hFFF1}) $display("FAIL signed_neg_row0: got %h want 0000fff1", got2[0]); else passed++;
  endtask

  task automatic test_zero_k();
    int cyc;
    feed2(0, 1'b0, cyc);
    total++; if (s2.out_valid !== 1'b1) $display("FAIL zero_k_immediate_read: got %b want 1", s2.out_valid); else passed++;
    collect2();
    total++; if (got2[0] !== 32'h0) $display("FAIL zero_k_row0: got %h want 0", got2[0]); else passed++;
    total++; if (got2[1] !== 32'h0) $display("FAIL zero_k_row1: got %h want 0", got2[1]); else passed++;
    total++; if (done_a !== 1'b1) $display("FAIL zero_k_done: got %b want 1", done_a); else passed++;
  endtask

  task automatic test_no_stall4();
    int cyc;
    for (int b = 0; b < 4; b++) begin
      w4[b] = {4{32'd2}};
      n4[b] = {4{32'd3}};
    end
    feed4(4, 1'b0, cyc);
    wait_valid4(cyc);
    total++; if (cyc != 11) $display("FAIL n4_latency: got %0d want 11", cyc); else passed++;
    collect4(4);
    total++; if (tmo !== 1'b0) $display("FAIL n4_timeout: got %b want 0", tmo); else passed++;
    for (int r = 0; r < 4; r++) begin
      total++; if (got4[r] !== {4{64'd24}}) $display("FAIL n4_row%0d: got %h want all 24", r, got4[r]); else passed++;
    end
    total++; if (grow4[3] !== 2'd3) $display("FAIL n4_rowidx3: got %0d want 3", grow4[3]); else passed++;
    total++; if (done_a !== 1'b1) $display("FAIL n4_done: got %b want 1", done_a); else passed++;
  endtask

  task automatic test_hold();
    int cyc;
    bit stable;
    logic [255:0] snap;
    feed4(4, 1'b1, cyc);
    wait_valid4(cyc);
    total++; if (s4.out_valid !== 1'b1) $display("FAIL stall_timeout: got %b want 1", s4.out_valid); else passed++;
    total++; if (s4.out_data !== {4{64'd24}}) $display("FAIL stall_row0: got %h want all 24", s4.out_data); else passed++;
    s4.out_ready = 1'b1;
    @(negedge clk);
    s4.out_ready = 1'b0;
    snap = s4.out_data;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      s4.start = (c == 4);
      s4.k_len = 8'd3;
      @(negedge clk);
      if (s4.out_data !== snap || s4.out_row !== 2'd1 || s4.out_valid !== 1'b1) stable = 1'b0;
    end
    s4.start = 1'b0;
    total++; if (stable !== 1'b1) $display("FAIL hold_stable: got %b want 1", stable); else passed++;
    total++; if (s4.out_row !== 2'd1) $display("FAIL hold_row: got %0d want 1", s4.out_row); else passed++;
    total++; if (snap !== {4{64'd24}}) $display("FAIL hold_row1_data: got %h want all 24", snap); else passed++;
    collect4(3);
    total++; if (grow4[2] !== 2'd3) $display("FAIL hold_last_rowidx: got %0d want 3", grow4[2]); else passed++;
    total++; if (got4[2] !== {4{64'd24}}) $display("FAIL hold_row3: got %h want all 24", got4[2]); else passed++;
    total++; if (done_a !== 1'b1) $display("FAIL hold_done: got %b want 1", done_a); else passed++;
    total++; if (s4.busy !== 1'b0) $display("FAIL hold_start_ignored: got busy %b want 0", s4.busy); else passed++;
  endtask

  task automatic test_reset_drain();
    int cyc;
    for (int b = 0; b < 4; b++) begin
      w4[b] = {4{32'd2}};
      n4[b] = {4{32'd3}};
    end
    feed4(4, 1'b0, cyc);
    repeat (2) @(negedge clk);
    total++; if (s4.busy !== 1'b1 || s4.out_valid !== 1'b0) $display("FAIL drain_state: got busy %b valid %b want 1 0", s4.busy, s4.out_valid); else passed++;
    rst = 1'b1;
    s4.in_valid = 1'b1;
    @(negedge clk);
    total++; if (s4.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", s4.busy); else passed++;
    rst = 1'b0;
    @(negedge clk);
    s4.in_valid = 1'b0;
    w4[0] = {32'd0, 32'd0, 32'd0, 32'd1};
    n4[0] = {32'd0, 32'd0, 32'd0, 32'd1};
    feed4(1, 1'b0, cyc);
    wait_valid4(cyc);
    total++; if (cyc != 8) $display("FAIL fresh_latency: got %0d want 8", cyc); else passed++;
    collect4(4);
    total++; if (got4[0] !== {192'd0, 64'd1}) $display("FAIL fresh_row0: got %h want 1", got4[0]); else passed++;
    for (int r = 1; r < 4; r++) begin
      total++; if (got4[r] !== 256'd0) $display("FAIL fresh_row%0d: got %h want 0", r, got4[r]); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    s2.start = 1'b0; s2.k_len = '0; s2.in_valid = 1'b0; s2.inp_west = '0; s2.inp_north = '0; s2.out_ready = 1'b0;
    s4.start = 1'b0; s4.k_len = '0; s4.in_valid = 1'b0; s4.inp_west = '0; s4.inp_north = '0; s4.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_identity();
    test_signed_dw8();
    test_zero_k();
    test_no_stall4();
    test_hold();
    test_reset_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
